// File: rtl/alu2_wb_buffer.sv
// Secondary-ALU writeback buffer: in-order FIFO of {result, dst, we} with an ESP forwarding tap.
// Latency: 1 cycle from accepted push to wb_* (no bypass); ESP forward is combinational over stored entries.
// Backpressure: ex_ready = occupancy < DEPTH from registered state only; wb_* hold while wb_valid & !wb_ready.
//
// Ports:
//   clk, rst (async active-low)
//   ex_valid/ex_ready, alu_res2, res2_dst, res2_we : capture side from execute
//   flush                                          : synchronous flush, beats push/pop
//   wb_valid/wb_ready, wb_res2, wb_dst, wb_we      : head entry to writeback
//   fwd_esp_hit, fwd_esp_data                      : youngest buffered ESP write
//   occupancy                                      : number of valid entries
module alu2_wb_buffer #(
  parameter int         DEPTH   = 2,
  parameter int         DATA_W  = 32,
  parameter logic [2:0] ESP_IDX = 3'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [DATA_W-1:0]        alu_res2,
  input  logic [2:0]               res2_dst,
  input  logic                     res2_we,
  input  logic                     flush,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_res2,
  output logic [2:0]               wb_dst,
  output logic                     wb_we,
  output logic                     fwd_esp_hit,
  output logic [DATA_W-1:0]        fwd_esp_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [2:0]        dst;
    logic              we;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic             push, pop;
  entry_t           head;

  // Full blocks a push even when the head pops in the same cycle, which
  // keeps wb_ready out of the ex_ready path.
  assign ex_ready  = (occ_q < FULL_CNT);
  assign occupancy = occ_q;

  assign head      = mem_q[rd_ptr_q];
  assign wb_valid  = vld_q[rd_ptr_q];
  assign wb_res2   = wb_valid ? head.res : '0;
  assign wb_dst    = wb_valid ? head.dst : 3'd0;
  assign wb_we     = wb_valid & head.we;

  assign push = ex_valid & ex_ready;
  assign pop  = wb_valid & wb_ready;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // Anything handshaken in the flush cycle is dropped.
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // push and pop never target the same slot: both require 0 < occ < DEPTH.
      if (pop) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q].res = alu_res2;
        mem_d[wr_ptr_q].dst = res2_dst;
        mem_d[wr_ptr_q].we  = res2_we;
        vld_d[wr_ptr_q]     = 1'b1;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [AW-1:0] idx;
    idx          = '0;
    fwd_esp_hit  = 1'b0;
    fwd_esp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if (vld_q[idx] && mem_q[idx].we && (mem_q[idx].dst == ESP_IDX)) begin
        fwd_esp_hit  = 1'b1;
        fwd_esp_data = mem_q[idx].res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_alu2_wb_buffer.sv
// Self-checking bench for alu2_wb_buffer: directed scenarios plus random traffic,
// checked by a queue-based reference model sampled on the falling edge.
module tb_alu2_wb_buffer;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] alu_res2;
  logic [2:0]        res2_dst;
  logic              res2_we;
  logic              flush;
  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_res2;
  logic [2:0]        wb_dst;
  logic              wb_we;
  logic              fwd_esp_hit;
  logic [DATA_W-1:0] fwd_esp_data;
  logic [1:0]        occupancy;

  alu2_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ESP_IDX(3'd4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_res2(alu_res2), .res2_dst(res2_dst), .res2_we(res2_we),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_res2(wb_res2), .wb_dst(wb_dst), .wb_we(wb_we),
    .fwd_esp_hit(fwd_esp_hit), .fwd_esp_data(fwd_esp_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  dst;
    logic        we;
  } ent_t;

  ent_t        sb[$];    // expected buffer contents, oldest first
  logic [31:0] dlv[$];   // results delivered to writeback
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model + monitor: compare DUT outputs with the modelled queue,
  // then apply the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    int          n;
    logic        m_hit;
    logic [31:0] m_data;
    logic        do_push, do_pop;
    if (!rst) begin
      sb.delete();
    end else begin
      n      = sb.size();
      m_hit  = 1'b0;
      m_data = '0;
      for (int k = n - 1; k >= 0; k--) begin
        if (!m_hit && sb[k].we && sb[k].dst == 3'd4) begin
          m_hit  = 1'b1;
          m_data = sb[k].res;
        end
      end
      chk("ex_ready", ex_ready, (n < DEPTH) ? 1 : 0);
      chk("occupancy", occupancy, n);
      chk("wb_valid", wb_valid, (n > 0) ? 1 : 0);
      if (n > 0) begin
        chk("wb_res2", wb_res2, sb[0].res);
        chk("wb_dst", wb_dst, sb[0].dst);
        chk("wb_we", wb_we, sb[0].we);
      end else begin
        chk("wb_res2_idle", wb_res2, 0);
        chk("wb_dst_idle", wb_dst, 0);
        chk("wb_we_idle", wb_we, 0);
      end
      chk("fwd_esp_hit", fwd_esp_hit, m_hit);
      chk("fwd_esp_data", fwd_esp_data, m_data);

      if (flush) begin
        sb.delete();
      end else begin
        do_pop  = (n > 0) && wb_ready;
        do_push = ex_valid && (n < DEPTH);
        if (do_pop) begin
          dlv.push_back(sb[0].res);
          void'(sb.pop_front());
        end
        if (do_push) begin
          sb.push_back('{res: alu_res2, dst: res2_dst, we: res2_we});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] d, input logic [2:0] dst,
                     input logic we, input logic rdy, input logic fl);
    ex_valid = v;
    alu_res2 = d;
    res2_dst = dst;
    res2_we  = we;
    wb_ready = rdy;
    flush    = fl;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ex_ready"}, ex_ready, 1);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_res2"}, wb_res2, 0);
    chk({tag, "_wb_dst"}, wb_dst, 0);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_fwd_hit"}, fwd_esp_hit, 0);
    chk({tag, "_fwd_data"}, fwd_esp_data, 0);
    chk({tag, "_occ"}, occupancy, 0);
  endtask

  initial begin
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk_reset_outputs("rst");
    rst = 1'b1;
    step();

    // Single transfer into an empty buffer.
    drv(1, 32'h1000, 3'd4, 1, 1, 0);
    step();
    drv(0, 0, 0, 0, 1, 0);
    chk("single_vld", wb_valid, 1);
    chk("single_res", wb_res2, 32'h1000);
    chk("single_dst", wb_dst, 4);
    chk("single_hit", fwd_esp_hit, 1);
    step();
    chk("single_vld_after", wb_valid, 0);
    chk("single_hit_after", fwd_esp_hit, 0);

    // Backpressure to full; third offer is refused.
    drv(1, 32'h11, 3'd1, 1, 0, 0); step();
    drv(1, 32'h22, 3'd2, 1, 0, 0); step();
    chk("full_ex_ready", ex_ready, 0);
    chk("full_occ", occupancy, 2);
    drv(1, 32'h33, 3'd3, 1, 0, 0); step();
    chk("full_occ_hold", occupancy, 2);
    chk("full_head_hold", wb_res2, 32'h11);
    drv(0, 0, 0, 0, 1, 0);
    step();
    chk("bp_second", wb_res2, 32'h22);
    chk("bp_ready_back", ex_ready, 1);
    step();
    chk("bp_empty", wb_valid, 0);

    // Simultaneous push and pop at occupancy 1.
    drv(1, 32'hA, 3'd0, 1, 0, 0); step();
    drv(1, 32'hB, 3'd0, 1, 1, 0); step();
    chk("pp_occ", occupancy, 1);
    chk("pp_head", wb_res2, 32'hB);
    drv(0, 0, 0, 0, 1, 0); step();

    // Back-to-back stream wraps the pointers several times.
    dlv.delete();
    for (int i = 0; i < 10; i++) begin
      drv(1, i, 3'd5, 1, 1, 0);
      step();
    end
    drv(0, 0, 0, 0, 1, 0);
    repeat (2) step();
    chk("wrap_count", dlv.size(), 10);
    for (int i = 0; i < 10 && i < dlv.size(); i++) chk("wrap_data", dlv[i], i);

    // Youngest ESP write wins; we=0 never forwards.
    drv(1, 32'h100, 3'd4, 1, 0, 0); step();
    drv(1, 32'h0FE, 3'd4, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("esp_young_data", fwd_esp_data, 32'h0FE);
    wb_ready = 1'b1; step();
    wb_ready = 1'b0;
    chk("esp_pop1_hit", fwd_esp_hit, 1);
    chk("esp_pop1_data", fwd_esp_data, 32'h0FE);
    wb_ready = 1'b1; step();
    chk("esp_pop2_hit", fwd_esp_hit, 0);
    drv(1, 32'h77, 3'd4, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("esp_we0_hit", fwd_esp_hit, 0);
    wb_ready = 1'b1; step();

    // Flush discards contents and a coincident push.
    dlv.delete();
    drv(1, 32'h41, 3'd1, 1, 0, 0); step();
    drv(1, 32'h42, 3'd2, 1, 0, 0); step();
    drv(1, 32'h55, 3'd3, 1, 0, 1); step();
    drv(0, 0, 0, 0, 1, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_vld", wb_valid, 0);
    chk("flush_ex_ready", ex_ready, 1);
    repeat (3) step();
    chk("flush_nothing_delivered", dlv.size(), 0);

    // Asynchronous reset between edges with an entry held.
    drv(1, 32'h99, 3'd4, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0);
    chk("arst_pre_occ", occupancy, 1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("arst");
    step();
    rst = 1'b1;
    step();
    drv(1, 32'h123, 3'd6, 1, 1, 0); step();
    drv(0, 0, 0, 0, 1, 0);
    chk("arst_after_res", wb_res2, 32'h123);
    chk("arst_after_dst", wb_dst, 6);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 1),
          $urandom,
          ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 31) == 0);
      step();
    end
    drv(0, 0, 0, 0, 1, 0);
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
